// File: rtl/stream_burst_sched.sv
// stream_burst_sched
// Sequencer for the stream gate. One accepted start produces a train of
// bursts: each burst is a single trig pulse to the gate, followed by a wait
// for the gate's last beat, then a programmable idle gap before the next trig.
//
// Optional build macro: STREAM_SCHED_WDOG_EN adds a watchdog that aborts a
// train whose burst never completes (err pulse, back to IDLE).
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   start_i, abort_i        single-cycle control requests
//   num_bursts_i            bursts per train, 0 = continuous until abort
//   burst_samples_i         samples per burst (0 rejects the start)
//   gap_cycles_i            idle cycles between a burst end and the next trig
//   mon_tvalid_i/tready_i/tlast_i  tap of the gate output handshake
//   trig_o, samples_o       gate trigger and latched burst length
//   busy_o, done_o, err_o   status: running / normal completion / watchdog
//   burst_idx_o             bursts completed in the current train
module stream_burst_sched #(
  parameter int CNT_WIDTH   = 32,
  parameter int IDX_WIDTH   = 16,
  parameter int WDOG_CYCLES = 1048576
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [IDX_WIDTH-1:0] num_bursts_i,
  input  logic [CNT_WIDTH-1:0] burst_samples_i,
  input  logic [CNT_WIDTH-1:0] gap_cycles_i,
  input  logic                 mon_tvalid_i,
  input  logic                 mon_tready_i,
  input  logic                 mon_tlast_i,
  output logic                 trig_o,
  output logic [CNT_WIDTH-1:0] samples_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IDX_WIDTH-1:0] burst_idx_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_LAST,
    ST_GAP,
    ST_DRAIN
  } state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] samples_q;
  logic [CNT_WIDTH-1:0] gap_q;
  logic [CNT_WIDTH-1:0] gap_cnt_q;
  logic [IDX_WIDTH-1:0] num_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [IDX_WIDTH-1:0] idx_d;
  logic                 done_q;
  logic                 err_q;
  logic                 burst_end;
  logic                 accept;
  logic                 wdog_hit;

  assign burst_end = mon_tvalid_i & mon_tready_i & mon_tlast_i;
  assign accept    = start_i & ~abort_i & (burst_samples_i != '0);
  assign idx_d     = idx_q + IDX_WIDTH'(1);

`ifdef STREAM_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_run;

  // Counts only while sitting in WAIT_LAST/DRAIN; any burst end or state
  // change (abort to DRAIN, timeout to IDLE) restarts it from zero.
  assign wdog_hit = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
  assign wdog_run = ((state_q == ST_WAIT_LAST && !abort_i) || state_q == ST_DRAIN)
                    && !burst_end && !wdog_hit;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       wdog_q <= '0;
    else if (wdog_run) wdog_q <= wdog_q + WDOG_W'(1);
    else               wdog_q <= '0;
  end
`else
  // No watchdog in this build: the timeout condition can never be met.
  assign wdog_hit = (WDOG_CYCLES < 0);
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      samples_q <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            samples_q <= burst_samples_i;
            num_q     <= num_bursts_i;
            gap_q     <= gap_cycles_i;
            idx_q     <= '0;
            state_q   <= ST_ARM;
          end
        end
        ST_ARM: begin
          // trig is out this cycle, so an abort must still wait for the burst
          state_q <= abort_i ? ST_DRAIN : ST_WAIT_LAST;
        end
        ST_WAIT_LAST: begin
          if (burst_end) begin
            idx_q <= idx_d;
            // abort coinciding with the last beat: burst is already over
            if (abort_i) begin
              state_q <= ST_IDLE;
            end else if (num_q != '0 && idx_d == num_q) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else if (gap_q == '0) begin
              state_q <= ST_ARM;
            end else begin
              gap_cnt_q <= gap_q;
              state_q   <= ST_GAP;
            end
          end else if (abort_i) begin
            state_q <= ST_DRAIN;
          end else if (wdog_hit) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end
        end
        ST_GAP: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (gap_cnt_q == CNT_WIDTH'(1)) begin
            state_q <= ST_ARM;
          end else begin
            gap_cnt_q <= gap_cnt_q - CNT_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (burst_end) begin
            state_q <= ST_IDLE;
          end else if (wdog_hit) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trig_o      = (state_q == ST_ARM);
  assign busy_o      = (state_q != ST_IDLE);
  assign samples_o   = samples_q;
  assign done_o      = done_q;
  assign burst_idx_o = idx_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_stream_burst_sched.sv
// Testbench for stream_burst_sched: directed trains from the test plan plus
// a randomized run, all checked every cycle against a timeline model that
// predicts trig cycles, completion cycles and the completed-burst count.
module tb_stream_burst_sched;
  localparam int CW = 8;
  localparam int IW = 3;
  localparam int WD = 16;
`ifdef STREAM_SCHED_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [IW-1:0] num_bursts;
  logic [CW-1:0] burst_samples, gap_cycles;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic          trig, busy, done, err;
  logic [CW-1:0] samples;
  logic [IW-1:0] burst_idx;

  always #5 clk = ~clk;

  stream_burst_sched #(.CNT_WIDTH(CW), .IDX_WIDTH(IW), .WDOG_CYCLES(WD)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .num_bursts_i(num_bursts), .burst_samples_i(burst_samples),
    .gap_cycles_i(gap_cycles), .mon_tvalid_i(mon_tvalid),
    .mon_tready_i(mon_tready), .mon_tlast_i(mon_tlast),
    .trig_o(trig), .samples_o(samples), .busy_o(busy), .done_o(done),
    .burst_idx_o(burst_idx), .err_o(err)
  );

  int     tests = 0, fails = 0;
  longint cyc = 0;
  int     trig_cnt, done_cnt, err_cnt;
  bit     prev_trig;
  longint last_trig;

  // Reference model: a train is "active"; a burst is "open" from its trig
  // until its last beat; "drain" means an abort is waiting for that beat.
  // Trig and completion are kept as absolute predicted cycle numbers.
  bit            m_active, m_open, m_drain;
  logic [CW-1:0] m_samples, m_gap;
  logic [IW-1:0] m_nb, m_idx;
  longint        m_next_trig, m_done_cyc, m_err_cyc, m_wd_ref;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_open = 0; m_drain = 0;
    m_samples = '0; m_gap = '0; m_nb = '0; m_idx = '0;
    m_next_trig = -1; m_done_cyc = -1; m_err_cyc = -1; m_wd_ref = 0;
    prev_trig = 0;
  endtask

  task automatic end_train();
    m_active = 0; m_open = 0; m_drain = 0; m_next_trig = -1;
  endtask

  task automatic wd_check();
    if (WD_EN && (cyc + 1 - m_wd_ref == WD)) begin
      end_train();
      m_err_cyc = cyc + 1;
    end
  endtask

  // Apply the rules for the clock edge that ends cycle 'cyc'.
  task automatic model_edge(input bit st, input bit ab, input logic [IW-1:0] nb,
                            input logic [CW-1:0] bs, input logic [CW-1:0] gap, input bit e);
    if (!m_active) begin
      if (st && !ab && bs != 0) begin
        m_active = 1; m_samples = bs; m_nb = nb; m_gap = gap; m_idx = '0;
        m_next_trig = cyc + 1; m_open = 0; m_drain = 0;
      end
    end else if (m_next_trig == cyc) begin
      m_next_trig = -1; m_open = 1; m_wd_ref = cyc + 1;
      if (ab) m_drain = 1;
    end else if (m_drain) begin
      if (e) end_train(); else wd_check();
    end else if (m_open) begin
      if (e) begin
        m_idx  = m_idx + 1'b1;
        m_open = 0;
        if (ab) end_train();
        else if (m_nb != 0 && m_idx == m_nb) begin end_train(); m_done_cyc = cyc + 1; end
        else m_next_trig = cyc + longint'(m_gap) + 1;
      end else if (ab) begin
        m_drain = 1; m_wd_ref = cyc + 1;
      end else wd_check();
    end else if (ab) begin
      end_train();
    end
  endtask

  task automatic check_outputs();
    chk("trig",    trig,      m_next_trig == cyc);
    chk("busy",    busy,      m_active);
    chk("done",    done,      m_done_cyc == cyc);
    chk("err",     err,       m_err_cyc == cyc);
    chk("idx",     burst_idx, m_idx);
    chk("samples", samples,   m_samples);
    if (prev_trig) chk("trig_back2back", trig, 1'b0);
    prev_trig = trig;
    trig_cnt += int'(trig);
    done_cnt += int'(done);
    err_cnt  += int'(err);
  endtask

  // Called at a falling edge: check this cycle, drive inputs for the next
  // rising edge, advance the model, move to the next falling edge.
  task automatic step(input bit st, input bit ab, input logic [IW-1:0] nb,
                      input logic [CW-1:0] bs, input logic [CW-1:0] gap,
                      input bit v, input bit r, input bit l);
    check_outputs();
    start = st; abort = ab; num_bursts = nb; burst_samples = bs; gap_cycles = gap;
    mon_tvalid = v; mon_tready = r; mon_tlast = l;
    model_edge(st, ab, nb, bs, gap, v & r & l);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 0; abort = 0; num_bursts = '0; burst_samples = '0; gap_cycles = '0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    #1;
    chk("rst_trig", trig, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_idx", burst_idx, '0);
    chk("rst_samples", samples, '0);
    model_clear();
    @(negedge clk);
    cyc++;
    reset = 1'b0;
  endtask

  // Start a train with an always-ready sink; each burst's last beat arrives
  // 'lat' cycles after its trig. Optionally abort in the gap that follows
  // burst number ab_idx.
  task automatic run_auto(input int n, input logic [IW-1:0] nb, input logic [CW-1:0] bs,
                          input logic [CW-1:0] gap, input int lat, input int ab_idx);
    bit ab_sent, st, ab, e;
    ab_sent = 0;
    last_trig = -100;
    for (int k = 0; k < n; k++) begin
      st = (k == 0);
      e  = (cyc == last_trig + lat);
      if (m_next_trig == cyc) last_trig = cyc;
      ab = 0;
      if (ab_idx != 0 && !ab_sent && m_active && !m_open && !m_drain &&
          m_next_trig > cyc && int'(m_idx) == ab_idx) begin
        ab = 1; ab_sent = 1;
      end
      step(st, ab, nb, bs, gap, 1'b1, 1'b1, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 0; abort = 0; num_bursts = '0; burst_samples = '0; gap_cycles = '0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();

    // 3 bursts of 4 samples, gap 5
    trig_cnt = 0; done_cnt = 0;
    run_auto(60, 3'd3, 8'd4, 8'd5, 5, 0);
    chk("t1_trigs", trig_cnt, 3);
    chk("t1_done", done_cnt, 1);
    chk("t1_idx", burst_idx, 3'd3);

    // zero gap: re-trigger right after the last beat
    trig_cnt = 0; done_cnt = 0;
    run_auto(30, 3'd2, 8'd3, 8'd0, 3, 0);
    chk("t2_trigs", trig_cnt, 2);
    chk("t2_done", done_cnt, 1);

    // abort in WAIT_LAST, start during DRAIN ignored, last beat 10 cycles later
    done_cnt = 0;
    step(1, 0, 3'd2, 8'd4, 8'd1, 1, 1, 0);
    step(0, 0, 3'd2, 8'd4, 8'd1, 1, 1, 0);
    step(0, 0, 3'd2, 8'd4, 8'd1, 1, 1, 0);
    step(0, 1, 3'd2, 8'd4, 8'd1, 1, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 3'd2, 8'd4, 8'd1, 1, 1, 0);
    step(1, 0, 3'd5, 8'd7, 8'd2, 1, 1, 0);
    chk("t3_busy_drain", busy, 1'b1);
    for (int k = 0; k < 4; k++) step(0, 0, 3'd2, 8'd4, 8'd1, 1, 1, 0);
    step(0, 0, 3'd2, 8'd4, 8'd1, 1, 1, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 3'd2, 8'd4, 8'd1, 1, 1, 0);
    chk("t3_done", done_cnt, 0);
    chk("t3_idx", burst_idx, 3'd0);
    chk("t3_samples", samples, 8'd4);
    chk("t3_busy_end", busy, 1'b0);

    // continuous mode, abort in the 4th gap
    done_cnt = 0;
    run_auto(80, 3'd0, 8'd2, 8'd3, 2, 4);
    chk("t4_idx", burst_idx, 3'd4);
    chk("t4_done", done_cnt, 0);
    chk("t4_busy", busy, 1'b0);

    // zero-length start is rejected
    trig_cnt = 0;
    step(1, 0, 3'd1, 8'd0, 8'd0, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 3'd1, 8'd0, 8'd0, 1, 1, 0);
    chk("t5_trigs", trig_cnt, 0);

    // no last beat: watchdog fires if built in, otherwise stays busy
    err_cnt = 0;
    step(1, 0, 3'd1, 8'd2, 8'd0, 1, 1, 0);
    for (int k = 0; k < 25; k++) step(0, 0, 3'd1, 8'd2, 8'd0, 1, 1, 0);
    chk("t6_err", err_cnt, WD_EN ? 1 : 0);
    chk("t6_busy", busy, !WD_EN);
    step(0, 1, 3'd1, 8'd2, 8'd0, 1, 1, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 3'd1, 8'd2, 8'd0, 1, 1, 0);

    // reset in the middle of a train
    step(1, 0, 3'd0, 8'd3, 8'd2, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 3'd0, 8'd3, 8'd2, 1, 1, 0);
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 0, 3'd0, 8'd3, 8'd2, 1, 1, 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      step($urandom_range(7) == 0, $urandom_range(39) == 0,
           3'($urandom_range(4)), 8'($urandom_range(3)), 8'($urandom_range(3)),
           $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(4) == 0);
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_burst_sched.md
# stream_burst_sched

Sequencer for the stream gate: turns one software start into a train of N gated bursts of a fixed sample count separated by a programmable idle gap. It drives the gate's `trig` and `samples` inputs and watches the gate's output handshake (`tvalid`, `tready`, `tlast`) to know when each burst has finished. It sits between the register bank and the stream gate, in the same clock domain as the gate.

## Interface
- `CNT_WIDTH`, default 32: width of the gap counter and of the `burst_samples`/`samples` ports.
- `IDX_WIDTH`, default 16: width of `num_bursts` and `burst_idx`.
- `WDOG_CYCLES`, default 1048576: watchdog timeout in cycles. Used only when `STREAM_SCHED_WDOG_EN` is defined.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle request to begin a burst train.
- `abort`  in  1: single-cycle request to stop scheduling.
- `num_bursts`  in  IDX_WIDTH: number of bursts; 0 = run continuously until abort.
- `burst_samples`  in  CNT_WIDTH: samples per burst; must be ≥1.
- `gap_cycles`  in  CNT_WIDTH: idle cycles between the end of one burst and the next trig.
- `mon_tvalid`, `mon_tready`, `mon_tlast`  in  1 each: tapped from the gate output stream.
- `trig`  out  1: trigger pulse to the gate.
- `samples`  out  CNT_WIDTH: latched burst length to the gate.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the train completes normally.
- `burst_idx`  out  IDX_WIDTH: number of bursts completed in the current train.
- `err`  out  1: one-cycle watchdog pulse; tied to 0 when the watchdog is compiled out.

## Operation
- Burst end event `E` = `mon_tvalid & mon_tready & mon_tlast`.
- States:
  - IDLE, ARM, WAIT_LAST, GAP, DRAIN.
  - `trig` = (state==ARM), decoded from the state register only.
  - `busy` = (state!=IDLE).
- IDLE:
  - On `start & ~abort & (burst_samples!=0)`: latch `burst_samples` into `samples`, latch `num_bursts` and `gap_cycles`, clear `burst_idx`, go to ARM.
  - A start with `burst_samples==0` is ignored and the block stays in IDLE.
- ARM: lasts exactly one cycle, then WAIT_LAST.
- WAIT_LAST: on `E`, increment `burst_idx`. Then:
  - If `num_bursts!=0` and the new `burst_idx==num_bursts`: go to IDLE and pulse `done`.
  - Otherwise, if `gap_cycles==0`: go to ARM.
  - Otherwise: load the gap counter and go to GAP.
- GAP: count `gap_cycles` cycles, then go to ARM.
- Abort:
  - In GAP: go to IDLE.
  - In ARM or WAIT_LAST: a burst is already in flight, so go to DRAIN.
  - In IDLE or DRAIN: ignored.
  - `done` is never pulsed after an abort.
- DRAIN: wait for `E`, then go to IDLE.
  - `burst_idx` is not incremented.
  - This keeps the scheduler from re-triggering a gate that is still running.
- While busy:
  - `start` is ignored.
  - `samples` and the latched parameters are held constant; live input changes have no effect until the next accepted start.
- `burst_idx` wraps modulo 2^IDX_WIDTH in continuous mode.

## Timing
- Reset values: state IDLE, `trig`=0, `samples`=0, `busy`=0, `done`=0, `burst_idx`=0, `err`=0, all counters 0.
- Reset asserted mid-train: everything returns to reset values immediately, with no done and no err.
- `start` accepted in cycle 0:
  - `trig`=1 and `busy`=1 in cycle 1.
  - State is WAIT_LAST from cycle 2.
- `E` sampled in cycle t:
  - `gap_cycles`=G>0: GAP occupies cycles t+1..t+G; `trig`=1 in cycle t+G+1.
  - G=0: `trig`=1 in cycle t+1.
- Final `E` in cycle t: `done`=1 and `busy`=0 in cycle t+1. `burst_idx` updates in cycle t+1.
- `trig` is never high in two consecutive cycles. There is at least one low cycle between trig pulses.
- `start` and `abort` in the same cycle while in IDLE: the block stays in IDLE.

## Configuration
- `STREAM_SCHED_WDOG_EN` defined:
  - A watchdog counter runs while in WAIT_LAST or DRAIN and clears on every `E` and on every state change.
  - Reaching `WDOG_CYCLES` forces IDLE and pulses `err` for one cycle; no `done`.
- `STREAM_SCHED_WDOG_EN` undefined: no watchdog logic; `err` is constant 0; WAIT_LAST and DRAIN wait indefinitely.

## Test plan
- `num_bursts`=3, `burst_samples`=4, `gap_cycles`=5, sink always ready → exactly 3 trig pulses, 5 idle cycles between each `E` and the next trig, `burst_idx` 1,2,3, a single `done` pulse one cycle after the third `E`.
- `gap_cycles`=0, `num_bursts`=2 → second trig in the cycle immediately after the first `E`; `trig` never high for 2 consecutive cycles.
- Abort in WAIT_LAST, then `E` 10 cycles later → `busy` stays 1 until the cycle after `E`; no `done`; a new start issued during DRAIN is ignored; `burst_idx` unchanged.
- `num_bursts`=0, abort during the 4th GAP → IDLE the next cycle, `burst_idx`=4, no `done`.
- `burst_samples`=0 with start → no trig, `busy` stays 0. Start asserted while busy → latched `samples` unchanged.
- With `STREAM_SCHED_WDOG_EN` and `WDOG_CYCLES`=16, `mon_tlast` held 0 → `err` pulses exactly 16 cycles after entering WAIT_LAST, then `busy`=0; without the macro, `busy` stays 1 and `err` stays 0.
